aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 36 +++
 rtl/aes_sub_word.sv | 12 +
 rtl/aes_round_ctrl.sv | 86 ++++++++
 tb/tb_aes_round_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants: widths, round count, Rcon, S-box and round-controller state type.
package aes_pkg;

  localparam int WORD_W     = 32;
  localparam int BLOCK_W    = 128;
  localparam int AES_ROUNDS = 10;
  localparam logic [3:0] LAST_ROUND = 4'(AES_ROUNDS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} aes_state_e;

  // Indexed by the round being produced; entry 0 and entries past 10 are never used for a key update.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic [WORD_W-1:0] o_word
);

  assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                   SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer with on-the-fly key expansion, one round per non-stalled cycle.
// Start accepted in IDLE only; done pulses 12 cycles after acceptance plus one per stalled cycle.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [0:BLOCK_W-1] cipher_key,
  input  logic               stall,
  output logic               ready,
  output logic [0:BLOCK_W-1] round_key,
  output logic [3:0]         round_idx,
  output logic               step,
  output logic               first_round,
  output logic               last_round,
  output logic               done
);

  aes_state_e          r_state;
  aes_state_e          w_state_nxt;
  logic [3:0]          r_idx;
  logic [BLOCK_W-1:0]  r_key;
  logic [BLOCK_W-1:0]  w_key_nxt;
  logic [WORD_W-1:0]   w_w0, w_w1, w_w2, w_w3;
  logic [WORD_W-1:0]   w_sub;
  logic [WORD_W-1:0]   w_n0, w_n1, w_n2, w_n3;
  logic                w_run;

  assign w_run = (r_state == ST_RUN);

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;

  aes_sub_word u_sub_word (
    .i_word ({w_w3[23:0], w_w3[31:24]}),
    .o_word (w_sub)
  );

  assign w_n0      = w_w0 ^ w_sub ^ {RCON[r_idx + 4'd1], 24'h000000};
  assign w_n1      = w_w1 ^ w_n0;
  assign w_n2      = w_w2 ^ w_n1;
  assign w_n3      = w_w3 ^ w_n2;
  assign w_key_nxt = {w_n0, w_n1, w_n2, w_n3};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (!stall && r_idx == LAST_ROUND) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 4'd0;
      r_key   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: if (start) begin
          r_key <= cipher_key;
          r_idx <= 4'd0;
        end
        // The final round keeps its key; there is no round 11 to expand into.
        ST_RUN: if (!stall && r_idx != LAST_ROUND) begin
          r_key <= w_key_nxt;
          r_idx <= r_idx + 4'd1;
        end
        ST_DONE: r_idx <= 4'd0;
        default: r_idx <= 4'd0;
      endcase
    end
  end

  assign ready       = (r_state == ST_IDLE);
  assign step        = w_run && !stall;
  assign first_round = w_run && (r_idx == 4'd0);
  assign last_round  = w_run && (r_idx == LAST_ROUND);
  assign done        = (r_state == ST_DONE);
  assign round_idx   = ready ? 4'd0 : r_idx;
  assign round_key   = ready ? '0 : r_key;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: FIPS-197 key schedules, stall, held start, mid-run reset.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [0:127] cipher_key;
  logic         stall;
  logic         ready;
  logic [0:127] round_key;
  logic [3:0]   round_idx;
  logic         step;
  logic         first_round;
  logic         last_round;
  logic         done;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [0:127] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [0:127] KEY_A_R4 = 128'hef44a541a8525b7fb671253bdb0bad00;
  localparam logic [0:127] KEY_A_RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [0:127] KEY_Z_R1 = 128'h62636363626363636263636362636363;
  localparam logic [0:127] KEY_Z_RA = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cipher_key  (cipher_key),
    .stall       (stall),
    .ready       (ready),
    .round_key   (round_key),
    .round_idx   (round_idx),
    .step        (step),
    .first_round (first_round),
    .last_round  (last_round),
    .done        (done)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // One operation; the model index advances on every non-stalled RUN cycle.
  task automatic run_op(input logic [0:127] k, input int st_at, input int st_len,
                        input logic [0:127] e1, input logic [0:127] e4, input bit has4,
                        input logic [0:127] e10);
    int  idx;
    int  stalled;
    bit  sn;
    bit  fin;
    @(negedge clk);
    start = 1'b1;
    cipher_key = k;
    check("ready_before", ready, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    cipher_key = '0;
    idx = 0;
    stalled = 0;
    fin = 0;
    while (!fin) begin
      sn = (idx == st_at) && (stalled < st_len);
      stall = sn;
      @(negedge clk);
      check("idx", round_idx, idx);
      check("step", step, !sn);
      check("first", first_round, idx == 0);
      check("last", last_round, idx == 10);
      check("done_run", done, 0);
      check("ready_run", ready, 0);
      if (idx == 0) check("rk0", round_key, k);
      if (idx == 1) check("rk1", round_key, e1);
      if (idx == 4 && has4) check("rk4", round_key, e4);
      if (idx == 10) check("rk10", round_key, e10);
      @(posedge clk);
      #1;
      if (sn) stalled++;
      else if (idx == 10) fin = 1;
      else idx++;
    end
    stall = 1'b0;
    @(negedge clk);
    check("done_pulse", done, 1);
    check("first_done", first_round, 0);
    check("last_done", last_round, 0);
    check("ready_done", ready, 0);
    @(negedge clk);
    check("ready_after", ready, 1);
    check("done_after", done, 0);
    check("rk_idle", round_key, 0);
    check("idx_idle", round_idx, 0);
  endtask

  initial begin
    int acc[$];
    int nf, nl, nd, bad;

    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    cipher_key = '0;
    #2;
    check("rst_ready", ready, 1);
    check("rst_idx", round_idx, 0);
    check("rst_step", step, 0);
    check("rst_done", done, 0);
    check("rst_rk", round_key, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(KEY_A, -1, 0, KEY_A_R1, KEY_A_R4, 1'b1, KEY_A_RA);
    run_op(KEY_A, 4, 3, KEY_A_R1, KEY_A_R4, 1'b1, KEY_A_RA);
    run_op('0, -1, 0, KEY_Z_R1, '0, 1'b0, KEY_Z_RA);

    // start held high: accepts at 0, 13, 26, 39
    nf = 0; nl = 0; nd = 0; bad = 0;
    @(negedge clk);
    start = 1'b1;
    cipher_key = KEY_A;
    for (int c = 0; c < 40; c++) begin
      if (ready) acc.push_back(c);
      if (c < 26) begin
        nf += int'(first_round);
        nl += int'(last_round);
        nd += int'(done);
      end
      if ((first_round || last_round) && (ready || done)) bad++;
      @(negedge clk);
    end
    start = 1'b0;
    check("acc_count", acc.size(), 4);
    if (acc.size() >= 3) begin
      check("acc0", acc[0], 0);
      check("acc1", acc[1], 13);
      check("acc2", acc[2], 26);
    end
    check("first_cnt", nf, 2);
    check("last_cnt", nl, 2);
    check("done_cnt", nd, 2);
    check("flag_outside_run", bad, 0);
    repeat (14) @(negedge clk);
    check("held_idle", ready, 1);

    // mid-run asynchronous reset at round 6
    @(negedge clk);
    start = 1'b1;
    cipher_key = KEY_A;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_idx", round_idx, 6);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ready", ready, 1);
    check("arst_idx", round_idx, 0);
    check("arst_step", step, 0);
    check("arst_first", first_round, 0);
    check("arst_last", last_round, 0);
    check("arst_done", done, 0);
    check("arst_rk", round_key, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      nd += int'(done);
      if (!ready) bad++;
      @(negedge clk);
    end
    check("no_done_after_rst", nd, 0);
    check("idle_after_rst", bad, 0);
    run_op(KEY_A, -1, 0, KEY_A_R1, KEY_A_R4, 1'b1, KEY_A_RA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
